// File: rtl/stream_demux_12.sv
// Registered 1-to-2 stream demultiplexer: each accepted word lands in the output slot picked by in_sel.
// Each output keeps a single-entry register and a saturating count of completed transfers.
module stream_demux_12 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH-1:0] out0_data_q, out0_data_d;
  logic [WIDTH-1:0] out1_data_q, out1_data_d;
  logic             out0_valid_q, out0_valid_d;
  logic             out1_valid_q, out1_valid_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic slot0_free, slot1_free;
  logic accept, acc0, acc1;
  logic drain0, drain1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + 1'b1;
  endfunction

  // A slot can take a word when empty or when it is being drained this same cycle.
  assign slot0_free = !out0_valid_q || out0_ready;
  assign slot1_free = !out1_valid_q || out1_ready;
  assign in_ready   = in_sel ? slot1_free : slot0_free;

  assign accept = in_valid && in_ready;
  assign acc0   = accept && !in_sel;
  assign acc1   = accept && in_sel;
  assign drain0 = out0_valid_q && out0_ready;
  assign drain1 = out1_valid_q && out1_ready;

  always_comb begin
    out0_data_d  = out0_data_q;
    out1_data_d  = out1_data_q;
    out0_valid_d = out0_valid_q;
    out1_valid_d = out1_valid_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (acc0) begin
      out0_data_d  = in_data;
      out0_valid_d = 1'b1;
    end else if (drain0) begin
      out0_valid_d = 1'b0;
    end

    if (acc1) begin
      out1_data_d  = in_data;
      out1_valid_d = 1'b1;
    end else if (drain1) begin
      out1_valid_d = 1'b0;
    end

    if (drain0) cnt0_d = sat_inc(cnt0_q);
    if (drain1) cnt1_d = sat_inc(cnt1_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule
